// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared types and default sizing for the sequence scanner.
//   DEF_WORD_W : default width of the scanned word
//   DEF_PAT_W  : default width of the target pattern
//   state_t    : controller FSM states (binary encoded)
package seq_scan_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_PAT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: request/result bundle of the sequence scanner.
//   master : start, abort, data_word, pattern, scan_len out; results in
//   slave  : the scanner side (requests in; busy, done, match_count,
//            hit, first_pos out)
interface seq_scan_ctrl_if
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W
) ();

  localparam int IDX_W = $clog2(WORD_W);
  localparam int LEN_W = IDX_W + 1;

  logic              start;
  logic              abort;
  logic [WORD_W-1:0] data_word;
  logic [PAT_W-1:0]  pattern;
  logic [LEN_W-1:0]  scan_len;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  match_count;
  logic              hit;
  logic [IDX_W-1:0]  first_pos;

  modport master (
    output start, abort, data_word, pattern, scan_len,
    input  busy, done, match_count, hit, first_pos
  );

  modport slave (
    input  start, abort, data_word, pattern, scan_len,
    output busy, done, match_count, hit, first_pos
  );

endinterface

// File: rtl/scan_window_match.sv
// scan_window_match: sliding window over the serial bit stream.
//   clk, rst    : clock, synchronous active-high reset
//   clear_i     : empty the window (new scan or abort)
//   shift_i     : bit_i is valid this cycle and is shifted in
//   bit_i       : incoming bit (oldest bits end up at the window MSB)
//   pattern_i   : target pattern, MSB = oldest bit
//   match_o     : the bit shifted in this cycle completes a match
// Build option: SEQ_SCAN_OVERLAP_EN defined lets matches overlap; when
// undefined the fill counter restarts after every match.
module scan_window_match
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             match_o
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match;

  // Match is judged on the window as it will look after this shift, so the
  // bit arriving this cycle can complete a match in the same cycle.
  always_comb begin
    win_d  = {win_q[PAT_W-2:0], bit_i};
    fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    match  = shift_i && (fill_d == FILL_W'(PAT_W)) && (win_d == pattern_i);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      win_q  <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      win_q <= win_d;
`ifdef SEQ_SCAN_OVERLAP_EN
      fill_q <= fill_d;
`else
      fill_q <= match ? '0 : fill_d;
`endif
    end
  end

  assign match_o = match;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scans a captured word MSB first for a bit pattern and
// reports match count, hit flag and index of the first match.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_scan_ctrl_if.slave (start/abort/data_word/pattern/
//              scan_len in; busy/done/match_count/hit/first_pos out)
// Build option: SEQ_SCAN_OVERLAP_EN (handled in scan_window_match).
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  seq_scan_ctrl_if.slave   bus
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int LEN_W = IDX_W + 1;

  state_t            state_q;
  logic [WORD_W-1:0] word_q;
  logic [PAT_W-1:0]  pat_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              found_q;
  logic [IDX_W-1:0]  first_q, first_d;
  logic              busy_q, done_q, hit_q;
  logic [LEN_W-1:0]  match_count_q;
  logic [IDX_W-1:0]  first_pos_q;
  logic              accept, abort_shift, shift_en, win_match, last_bit;

  assign accept      = (state_q == ST_IDLE) && bus.start;
  assign abort_shift = (state_q == ST_SHIFT) && bus.abort;
  assign shift_en    = (state_q == ST_SHIFT) && !bus.abort;

  always_comb begin
    len_d    = (bus.scan_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : bus.scan_len;
    last_bit = ({1'b0, idx_q} + LEN_W'(1)) == len_q;
    // Final results include a match completed by the last shifted bit.
    cnt_d    = cnt_q + LEN_W'(win_match);
    first_d  = found_q ? first_q : (win_match ? idx_q : '0);
  end

  scan_window_match #(.PAT_W(PAT_W)) u_window (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept || abort_shift),
    .shift_i   (shift_en),
    .bit_i     (word_q[WORD_W-1]),
    .pattern_i (pat_q),
    .match_o   (win_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_q        <= '0;
      pat_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      found_q       <= 1'b0;
      first_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      match_count_q <= '0;
      first_pos_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            word_q  <= bus.data_word;
            pat_q   <= bus.pattern;
            len_q   <= len_d;
            idx_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            first_q <= '0;
            if (len_d == '0) begin
              state_q       <= ST_DONE;
              done_q        <= 1'b1;
              match_count_q <= '0;
              hit_q         <= 1'b0;
              first_pos_q   <= '0;
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            match_count_q <= '0;
            hit_q         <= 1'b0;
            first_pos_q   <= '0;
          end else begin
            word_q <= {word_q[WORD_W-2:0], 1'b0};
            idx_q  <= idx_q + IDX_W'(1);
            cnt_q  <= cnt_d;
            if (win_match && !found_q) begin
              found_q <= 1'b1;
              first_q <= idx_q;
            end
            if (last_bit) begin
              state_q       <= ST_DONE;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              match_count_q <= cnt_d;
              hit_q         <= (cnt_d != '0);
              first_pos_q   <= first_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match_count = match_count_q;
  assign bus.hit         = hit_q;
  assign bus.first_pos   = first_pos_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  localparam int WORD_W = 16;
  localparam int PAT_W  = 4;
`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.WORD_W(WORD_W), .PAT_W(PAT_W)) bus ();

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cnt;
    int first;
    int lat;
    int acc;
    int id;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int scan_id = 0;
  int last_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference: slide over the scanned bits, compare each PAT_W-bit slice
  // with the pattern; without overlap a slice may not reuse bits of the
  // previous match.
  function automatic void model(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                                input int len, output int cnt, output int first);
    int last_end;
    bit ok;
    last_end = -1;
    cnt = 0;
    first = 0;
    for (int i = PAT_W - 1; i < len; i++) begin
      ok = 1'b1;
      for (int k = 0; k < PAT_W; k++)
        if (w[WORD_W-1-(i-PAT_W+1+k)] != p[PAT_W-1-k]) ok = 1'b0;
      if (ok && (OVERLAP || (i - PAT_W + 1) > last_end)) begin
        if (cnt == 0) first = i;
        cnt++;
        last_end = i;
      end
    end
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("match_count", int'(bus.match_count), e.cnt);
        check("hit", int'(bus.hit), int'(e.cnt != 0));
        check("first_pos", int'(bus.first_pos), e.first);
        check("done_latency", cyc - e.acc + 1, e.lat);
        last_cnt = e.cnt;
        $display("[TB] scan %0d: count=%0d hit=%0d first=%0d latency=%0d", e.id,
                 bus.match_count, bus.hit, bus.first_pos, cyc - e.acc + 1);
      end
    end
  end

  task automatic check_cleared(string name);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_done"}, int'(bus.done), 0);
    check({name, "_count"}, int'(bus.match_count), 0);
    check({name, "_hit"}, int'(bus.hit), 0);
    check({name, "_first"}, int'(bus.first_pos), 0);
  endtask

  // Disturbances are placed in the k-th SHIFT cycle (1-based); -1 disables.
  task automatic run_scan(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                          input int sl, input int abort_at, input int start_at,
                          input int rst_at, input bit idle_abort);
    int len, cnt, first, t;
    exp_t e;
    len = (sl > WORD_W) ? WORD_W : sl;
    model(w, p, len, cnt, first);
    @(negedge clk);
    bus.data_word = w;
    bus.pattern   = p;
    bus.scan_len  = sl[4:0];
    bus.start     = 1'b1;
    bus.abort     = idle_abort;
    @(posedge clk);
    #1;
    if (abort_at < 0 && rst_at < 0) begin
      e = '{cnt, first, len + 1, cyc, scan_id};
      sb_q.push_back(e);
    end else begin
      $display("[TB] scan %0d: disturbed (abort_at=%0d rst_at=%0d), no result expected",
               scan_id, abort_at, rst_at);
    end
    scan_id++;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.data_word = ~w;
    check("busy_after_accept", int'(bus.busy), int'(len != 0));
    for (int k = 1; k <= len; k++) begin
      if (k == abort_at) bus.abort = 1'b1;
      if (k == start_at) bus.start = 1'b1;
      if (k == rst_at) rst = 1'b1;
      if (k == abort_at || k == start_at || k == rst_at) begin
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        if (k == abort_at || k == rst_at) begin
          check_cleared((k == rst_at) ? "reset_mid" : "abort");
          rst = 1'b0;
          break;
        end
      end
    end
    t = 0;
    while (sb_q.size() != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 0, 1);
      sb_q.delete();
    end
    if (abort_at >= 0 || rst_at >= 0) begin
      repeat (len + 4) @(negedge clk);
      check("after_abort_count", int'(bus.match_count), 0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [WORD_W-1:0] w1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.data_word = '0;
    bus.pattern   = '0;
    bus.scan_len  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    w1 = 16'b1011_0110_0000_0000;
    run_scan(w1, 4'b1011, 7, -1, -1, -1, 1'b0);
    run_scan(w1, 4'b1011, 0, -1, -1, -1, 1'b0);
    run_scan(w1, 4'b1011, 3, -1, -1, -1, 1'b0);
    run_scan(16'hFFFF, 4'hF, 31, -1, -1, -1, 1'b0);
    // start and abort together in IDLE: start wins
    run_scan(w1, 4'b1011, 7, -1, -1, -1, 1'b1);
    // abort in IDLE is ignored: results hold
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_hold", int'(bus.match_count), last_cnt);
    run_scan(16'hFFFF, 4'hF, 16, 5, -1, -1, 1'b0);
    run_scan(w1, 4'b1011, 10, -1, 3, -1, 1'b0);
    run_scan(16'hFFFF, 4'hF, 16, -1, -1, 4, 1'b0);
    run_scan(w1, 4'b1011, 7, -1, -1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [WORD_W-1:0] rw;
      logic [PAT_W-1:0]  rp;
      rw = WORD_W'($urandom);
      rp = PAT_W'($urandom);
      if (n % 4 == 0) rw = {rp, rp, rp, rp};
      run_scan(rw, rp, int'($urandom_range(0, 31)), -1, -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter WORD_W, 16, width of the scanned word; legal 4..32.
REQ-002 Parameter PAT_W, 4, width of the programmable pattern; legal 2..8, PAT_W <= WORD_W.
REQ-003 Port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  in  1  reset; synchronous, active-high.
REQ-005 Port start  in  1  request to scan; accepted only in IDLE.
REQ-006 Port abort  in  1  cancel an in-progress scan.
REQ-007 Port data_word  in  WORD_W  word to scan; captured on accept.
REQ-008 Port pattern  in  PAT_W  target bit pattern; captured on accept.
REQ-009 Port scan_len  in  clog2(WORD_W)+1  number of bits to scan.
REQ-010 Port busy  out  1  high in SHIFT state.
REQ-011 Port done  out  1  one-cycle pulse on scan completion.
REQ-012 Port match_count  out  clog2(WORD_W)+1  matches found in the last completed scan.
REQ-013 Port hit  out  1  at least one match in the last completed scan.
REQ-014 Port first_pos  out  clog2(WORD_W)  scan index of the bit completing the first match; 0 if none.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE; one-hot or binary at implementer's choice.
REQ-016 IDLE + start: capture data_word, pattern, and effective length L; clear window and count; go to SHIFT (or DONE if L=0).
REQ-017 L = scan_len clamped to WORD_W; scan_len=0 gives L=0, no bits shifted, match_count=0.
REQ-018 start is ignored in SHIFT and DONE; no queuing.
REQ-019 SHIFT presents one bit per cycle, MSB (bit WORD_W-1) first; scan index i counts 0..L-1.
REQ-020 Window = last PAT_W shifted bits plus a fill counter; match when fill >= PAT_W and window == pattern (MSB of pattern = oldest bit).
REQ-021 No match is possible while fewer than PAT_W bits are in the window, hence none when L < PAT_W.
REQ-022 On each match: increment the count; on the first match, latch first_pos = i.
REQ-023 After bit L-1, go to DONE; DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-024 Latency: done is high L+1 cycles after the start-accept edge (1 cycle for L=0).
REQ-025 match_count, hit and first_pos update together when DONE is entered and hold until the next DONE, abort or reset.
REQ-026 abort in SHIFT: return to IDLE next edge, no done pulse, result outputs cleared to 0; abort is ignored in IDLE and DONE.
REQ-027 abort and start in the same IDLE cycle: start wins.

Reset
REQ-028 rst forces IDLE, busy=0, done=0, match_count=0, hit=0, first_pos=0, window and fill cleared; rst overrides start/abort, including mid-SHIFT.

Configuration
REQ-029 Macro SEQ_SCAN_OVERLAP_EN defined: the window continues after a match, so overlapping matches count.
REQ-030 SEQ_SCAN_OVERLAP_EN undefined: on a match, fill resets to 0, so the next match needs PAT_W new bits (non-overlapping).

Structure
REQ-031 Package seq_scan_pkg holds the FSM state type/encodings and the default WORD_W/PAT_W constants.
REQ-032 Sub-module scan_window_match holds the window shift register, fill counter, compare and the overlap macro; seq_scan_ctrl holds the FSM, index, count and result registers.

Verification
REQ-033 PAT_W=4, pattern=1011, top bits 1011011 then zeros, L=7, overlap on -> match_count=2, first_pos=3, hit=1, done 8 cycles after accept.
REQ-034 Same stimulus, overlap off -> match_count=1, first_pos=3.
REQ-035 L=0 -> done at 1 cycle, count=0, hit=0; L=3 with word 1011... -> count=0.
REQ-036 scan_len=31, WORD_W=16, word=16'hFFFF, pattern=1111, overlap on -> L=16, count=13, done 17 cycles after accept.
REQ-037 abort at the 5th SHIFT cycle -> IDLE, no done, outputs 0; start during SHIFT -> ignored, results from the original word only.
REQ-038 rst asserted mid-SHIFT -> all outputs 0 next cycle; a subsequent start scans normally.
